score_sequencer: RTL

Sequencing controller for the memory game's score display path. It synchronizes the active-low answer key, classifies each press as correct or incorrect from `exist`, and updates the correct and incorrect counters. It then computes the hit percentage with a multi-cycle restoring divider and publishes a stable `correct`/`incorrect`/`percent` triple plus a `display_state` code for the seven-segment display stage.

---
 rtl/score_sequencer.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/score_sequencer.sv
// ---------------------------------------------------------------------------
// score_sequencer
//
// Score path controller for the memory game. Synchronizes the active-low
// answer key, classifies each press as correct or incorrect from i_exist,
// updates the working counters, then computes the hit percentage with a
// 14-step restoring divider. It publishes a mutually consistent
// correct/incorrect/percent triple plus a display state code.
//
// Optional feature macro: SCORE_SATURATE_EN
//    defined   : counters hold at MAX_CNT; reaching it ends the game (OVER).
//    undefined : counters wrap MAX_CNT -> 0; OVER is unreachable.
//
// Ports
//    i_clk            system clock, rising edge
//    i_reset          asynchronous active-high reset
//    i_input_key      raw answer pushbutton, active-low, asynchronous
//    i_exist          1 = presented item was in memory (answer correct)
//    o_correct        published correct count
//    o_incorrect      published incorrect count
//    o_percent        published floor(100*correct/(correct+incorrect))
//    o_display_state  0 = scores valid, 1 = computing, 2 = game over
//    o_busy           high in UPDATE, DIVIDE and PUBLISH
//    o_drop           sticky: a key event was lost (cleared by reset only)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a pending key event in the slot
// UPDATE  | bump the working counter, load dividend/divisor
// DIVIDE  | restoring divide, one quotient bit per cycle, 14 cycles
// PUBLISH | copy counters and quotient to the outputs
// OVER    | game over, terminal until reset
// ---------------------------------------------------------------------------
module score_sequencer #(
   parameter int CNT_W   = 7,
   parameter int MAX_CNT = 99
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_input_key,
   input  logic             i_exist,
   output logic [CNT_W-1:0] o_correct,
   output logic [CNT_W-1:0] o_incorrect,
   output logic [CNT_W-1:0] o_percent,
   output logic [2:0]       o_display_state,
   output logic             o_busy,
   output logic             o_drop
);

   localparam int DVD_W = 14;
   localparam int DVS_W = 8;

   localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_CNT);
   localparam logic [3:0]       DIV_LAST = 4'(DVD_W - 1);

   localparam logic [2:0] DS_VALID = 3'd0;
   localparam logic [2:0] DS_BUSY  = 3'd1;
   localparam logic [2:0] DS_OVER  = 3'd2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UPDATE  = 3'd1,
      S_DIVIDE  = 3'd2,
      S_PUBLISH = 3'd3,
      S_OVER    = 3'd4
   } state_t;

   // key synchronizer and edge detect
   logic r_key_meta;
   logic r_key_sync;
   logic r_key_prev;
   logic r_event;
   logic r_event_exist;

   // one-deep pending slot
   logic r_slot_full;
   logic r_slot_exist;
   logic r_drop;

   // sequencer
   state_t           r_state;
   logic             r_upd_exist;
   logic [CNT_W-1:0] r_correct;
   logic [CNT_W-1:0] r_incorrect;
   logic [DVD_W-1:0] r_quo;
   logic [DVS_W-1:0] r_rem;
   logic [DVS_W-1:0] r_divisor;
   logic [3:0]       r_div_cnt;

   // published outputs
   logic [CNT_W-1:0] r_pub_correct;
   logic [CNT_W-1:0] r_pub_incorrect;
   logic [CNT_W-1:0] r_pub_percent;
   logic [2:0]       r_disp;
   logic             r_busy;

   logic             w_consume;
   logic [CNT_W-1:0] w_new_correct;
   logic [CNT_W-1:0] w_new_incorrect;
   logic [DVD_W-1:0] w_dividend;
   logic [DVS_W-1:0] w_divisor;
   logic [DVS_W:0]   w_rem_shift;
   logic             w_q_bit;
   logic [DVS_W-1:0] w_rem_sub;
   logic [DVS_W-1:0] w_rem_next;
   logic             w_game_over;

   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] v);
`ifdef SCORE_SATURATE_EN
      return (v >= MAX_V) ? MAX_V : v + CNT_W'(1);
`else
      return (v == MAX_V) ? '0 : v + CNT_W'(1);
`endif
   endfunction

   // -------------------------------------------------------------------
   // Key path: two sync flops, then a registered falling-edge detect.
   // Sync flops reset to 1 (key released) so reset never fakes a press.
   // -------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_key_meta    <= 1'b1;
         r_key_sync    <= 1'b1;
         r_key_prev    <= 1'b1;
         r_event       <= 1'b0;
         r_event_exist <= 1'b0;
      end else begin
         r_key_meta    <= i_input_key;
         r_key_sync    <= r_key_meta;
         r_key_prev    <= r_key_sync;
         r_event       <= r_key_prev & ~r_key_sync;
         r_event_exist <= i_exist;
      end
   end

   // IDLE frees the slot in the same cycle it is read, so a coincident
   // event lands in the freed slot instead of being dropped.
   assign w_consume = (r_state == S_IDLE) && r_slot_full;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_slot_full  <= 1'b0;
         r_slot_exist <= 1'b0;
         r_drop       <= 1'b0;
      end else begin
         if (r_event && (r_state != S_OVER)) begin
            if (!r_slot_full || w_consume) begin
               r_slot_full  <= 1'b1;
               r_slot_exist <= r_event_exist;
            end else begin
               r_drop <= 1'b1;
            end
         end else if (w_consume) begin
            r_slot_full <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------
   // Counter update and divider operand preparation
   // -------------------------------------------------------------------
   always_comb begin
      w_new_correct   = r_correct;
      w_new_incorrect = r_incorrect;
      if (r_upd_exist) begin
         w_new_correct = cnt_step(r_correct);
      end else begin
         w_new_incorrect = cnt_step(r_incorrect);
      end
   end

   assign w_dividend = DVD_W'(w_new_correct) * DVD_W'(100);
   assign w_divisor  = DVS_W'(w_new_correct) + DVS_W'(w_new_incorrect);

   // Restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor when it fits. The true difference is always
   // below the divisor, so 8-bit modular subtraction is exact.
   assign w_rem_shift = {r_rem, r_quo[DVD_W-1]};
   assign w_q_bit     = (w_rem_shift >= {1'b0, r_divisor});
   assign w_rem_sub   = w_rem_shift[DVS_W-1:0] - r_divisor;
   assign w_rem_next  = w_q_bit ? w_rem_sub : w_rem_shift[DVS_W-1:0];

`ifdef SCORE_SATURATE_EN
   assign w_game_over = (r_correct == MAX_V) || (r_incorrect == MAX_V);
`else
   assign w_game_over = 1'b0;
`endif

   // -------------------------------------------------------------------
   // Sequencer with registered outputs
   // -------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_upd_exist     <= 1'b0;
         r_correct       <= '0;
         r_incorrect     <= '0;
         r_quo           <= '0;
         r_rem           <= '0;
         r_divisor       <= '0;
         r_div_cnt       <= '0;
         r_pub_correct   <= '0;
         r_pub_incorrect <= '0;
         r_pub_percent   <= '0;
         r_disp          <= DS_VALID;
         r_busy          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_slot_full) begin
                  r_upd_exist <= r_slot_exist;
                  r_busy      <= 1'b1;
                  r_disp      <= DS_BUSY;
                  r_state     <= S_UPDATE;
               end
            end

            S_UPDATE: begin
               r_correct   <= w_new_correct;
               r_incorrect <= w_new_incorrect;
               r_quo       <= w_dividend;
               r_rem       <= '0;
               r_divisor   <= w_divisor;
               r_div_cnt   <= DIV_LAST;
               r_state     <= S_DIVIDE;
            end

            // r_quo shifts dividend bits out of the top while quotient
            // bits enter at the bottom; after 14 steps it holds the quotient.
            S_DIVIDE: begin
               r_rem <= w_rem_next;
               r_quo <= {r_quo[DVD_W-2:0], w_q_bit};
               if (r_div_cnt == 4'd0) begin
                  r_state <= S_PUBLISH;
               end else begin
                  r_div_cnt <= r_div_cnt - 4'd1;
               end
            end

            // A zero divisor only happens when both counters wrapped to 0.
            S_PUBLISH: begin
               r_pub_correct   <= r_correct;
               r_pub_incorrect <= r_incorrect;
               r_pub_percent   <= (r_divisor == '0) ? '0 : r_quo[CNT_W-1:0];
               r_busy          <= 1'b0;
               if (w_game_over) begin
                  r_disp  <= DS_OVER;
                  r_state <= S_OVER;
               end else begin
                  r_disp  <= DS_VALID;
                  r_state <= S_IDLE;
               end
            end

            S_OVER: begin
               r_state <= S_OVER;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_correct       = r_pub_correct;
   assign o_incorrect     = r_pub_incorrect;
   assign o_percent       = r_pub_percent;
   assign o_display_state = r_disp;
   assign o_busy          = r_busy;
   assign o_drop          = r_drop;

endmodule
